branch_predict_unit: RTL and testbench

- Parametrised successor to the EX-stage branch comparator.
- Resolves all RV32I branch conditions for an XLEN-wide datapath.
- Holds a direct-mapped Branch History Table (BHT) of 2-bit saturating counters: read in IF, trained from EX.
- Flags mispredicts to the hazard unit and self-initialises the table through a sweep FSM after reset.

---
 rtl/branch_predict_unit_pkg.sv | 34 +++
 rtl/branch_compare.sv | 26 ++
 rtl/branch_predict_unit.sv | 121 ++++++++++++
 tb/tb_branch_predict_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - shared branch codes, FSM states and BHT counter helpers
package branch_predict_unit_pkg;

    localparam logic [2:0] NOBRANCH = 3'd0;
    localparam logic [2:0] BEQ      = 3'd1;
    localparam logic [2:0] BNE      = 3'd2;
    localparam logic [2:0] BLT      = 3'd3;
    localparam logic [2:0] BLTU     = 3'd4;
    localparam logic [2:0] BGE      = 3'd5;
    localparam logic [2:0] BGEU     = 3'd6;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpu_state_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic is_branch_code(input logic [2:0] code);
        return (code >= BEQ) && (code <= BGEU);
    endfunction

    // 2-bit saturating counter step toward the resolved outcome
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'b01;
        end
        return (ctr == SNT) ? SNT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational RV32I branch condition evaluator
module branch_compare
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      branch_type,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_type)
            BEQ:     taken = (op1 == op2);
            BNE:     taken = (op1 != op2);
            BLT:     taken = ($signed(op1) <  $signed(op2));
            BGE:     taken = ($signed(op1) >= $signed(op2));
            BLTU:    taken = (op1 <  op2);
            BGEU:    taken = (op1 >= op2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - branch resolve + 2-bit BHT predictor with init sweep
// Optional statistics counters built only when BRANCH_STATS_EN is defined.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         BHT_IDX  = 6,
    parameter logic [1:0] CTR_INIT = WNT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    input  logic            en_e,
    input  logic [2:0]      branch_type_e,
    input  logic [XLEN-1:0] op1_e,
    input  logic [XLEN-1:0] op2_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic            pred_taken_e,
    output logic            branch_e,
    output logic            mispredict_e,
    output logic            init_busy,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int BHT_SIZE = 1 << BHT_IDX;
    localparam logic [BHT_IDX:0] LAST_IDX = (BHT_IDX + 1)'(BHT_SIZE - 1);

    logic [1:0]         bht [BHT_SIZE];
    bpu_state_e         state, state_nxt;
    logic [BHT_IDX:0]   init_idx, init_idx_nxt;
    logic [BHT_IDX-1:0] idx_f, idx_e;
    logic [BHT_IDX-1:0] bht_wa;
    logic [1:0]         bht_wd;
    logic               bht_we;
    logic               cmp_taken;
    logic               is_br;

    assign idx_f = pc_f[BHT_IDX+1:2];
    assign idx_e = pc_e[BHT_IDX+1:2];

    branch_compare #(.XLEN(XLEN)) u_compare (
        .branch_type (branch_type_e),
        .op1         (op1_e),
        .op2         (op2_e),
        .taken       (cmp_taken)
    );

    assign branch_e     = en_e && cmp_taken;
    assign is_br        = en_e && is_branch_code(branch_type_e);
    assign mispredict_e = is_br && (branch_e != pred_taken_e);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else begin
            state    <= state_nxt;
            init_idx <= init_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        init_busy    = 1'b0;
        bht_we       = 1'b0;
        bht_wa       = idx_e;
        bht_wd       = ctr_update(bht[idx_e], branch_e);
        case (state)
            ST_INIT: begin
                init_busy    = 1'b1;
                bht_we       = 1'b1;
                bht_wa       = init_idx[BHT_IDX-1:0];
                bht_wd       = CTR_INIT;
                init_idx_nxt = init_idx + 1'b1;
                if (init_idx == LAST_IDX) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bht_we = is_br;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // No reset on the array: the sweep rewrites every entry before RUN
    always_ff @(posedge clk) begin
        if (!rst && bht_we) begin
            bht[bht_wa] <= bht_wd;
        end
    end

    assign pred_taken_f = (state == ST_RUN) && bht[idx_f][1];

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else if (state == ST_RUN) begin
            if (is_br) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict_e) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end
`else
    assign branch_cnt  = 32'd0;
    assign mispred_cnt = 32'd0;
`endif

    logic unused_bits;
    assign unused_bits = ^{pc_f[XLEN-1:BHT_IDX+2], pc_f[1:0],
                           pc_e[XLEN-1:BHT_IDX+2], pc_e[1:0], init_idx[BHT_IDX]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

    localparam logic [2:0] T_NOBR = 3'd0;
    localparam logic [2:0] T_BEQ  = 3'd1;
    localparam logic [2:0] T_BNE  = 3'd2;
    localparam logic [2:0] T_BLT  = 3'd3;
    localparam logic [2:0] T_BLTU = 3'd4;
    localparam logic [2:0] T_BGE  = 3'd5;
    localparam logic [2:0] T_BGEU = 3'd6;

`ifdef BRANCH_STATS_EN
    localparam logic [31:0] EXP_BCNT = 32'd3;
    localparam logic [31:0] EXP_MCNT = 32'd1;
`else
    localparam logic [31:0] EXP_BCNT = 32'd0;
    localparam logic [31:0] EXP_MCNT = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic        en_e;
    logic [2:0]  branch_type_e;
    logic [31:0] op1_e, op2_e, pc_e;
    logic        pred_taken_e;
    logic        branch_e, mispredict_e, init_busy;
    logic [31:0] branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_f          (pc_f),
        .pred_taken_f  (pred_taken_f),
        .en_e          (en_e),
        .branch_type_e (branch_type_e),
        .op1_e         (op1_e),
        .op2_e         (op2_e),
        .pc_e          (pc_e),
        .pred_taken_e  (pred_taken_e),
        .branch_e      (branch_e),
        .mispredict_e  (mispredict_e),
        .init_busy     (init_busy),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] b, input logic pred, input logic en);
        pc_e = pc; branch_type_e = t; op1_e = a; op2_e = b; pred_taken_e = pred; en_e = en;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_f = 32'h0; en_e = 1'b0; branch_type_e = T_NOBR;
        op1_e = '0; op2_e = '0; pc_e = '0; pred_taken_e = 1'b0;
        step(); step();
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", init_busy); end
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", pred_taken_f); end
        checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL reset_bcnt got=%0d exp=0", branch_cnt); end
        checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_mcnt got=%0d exp=0", mispred_cnt); end
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step();
            checks++;
            if (init_busy !== (k < 64)) begin
                errors++; $display("FAIL init_len cycle=%0d got=%b exp=%b", k, init_busy, (k < 64));
            end
        end
    endtask

    task automatic test_init_values();
        for (int i = 0; i < 64; i++) begin
            pc_f = 32'(i * 4);
            #1;
            checks++;
            if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL init_pred idx=%0d got=%b exp=0", i, pred_taken_f); end
        end
    endtask

    task automatic test_compare();
        logic [2:0]  t   [12] = '{T_BLT, T_BLTU, T_BGE, T_BGEU, T_BEQ, T_BNE, 3'd7, T_NOBR, T_BEQ, T_BNE, T_BGE, T_BLTU};
        logic [31:0] a   [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd1};
        logic [31:0] b   [12] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5, 32'd5, 32'd6, 32'd6, 32'd5, 32'hFFFF_FFFF};
        logic        exp [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            drive(32'h0000_00F0, t[i], a[i], b[i], 1'b0, 1'b1);
            checks++;
            if (branch_e !== exp[i]) begin errors++; $display("FAIL cmp_taken vec=%0d got=%b exp=%b", i, branch_e, exp[i]); end
            checks++;
            if (mispredict_e !== exp[i]) begin errors++; $display("FAIL cmp_mispred vec=%0d got=%b exp=%b", i, mispredict_e, exp[i]); end
        end
        en_e = 1'b0;
        step();
    endtask

    task automatic test_training();
        logic tk  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic exp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        pc_f = 32'h0000_0040;
        for (int i = 0; i < 8; i++) begin
            drive(32'h0000_0040, tk[i] ? T_BEQ : T_BNE, 32'd3, 32'd3, 1'b0, 1'b1);
            step();
            en_e = 1'b0;
            #1;
            checks++;
            if (pred_taken_f !== exp[i]) begin errors++; $display("FAIL train step=%0d got=%b exp=%b", i, pred_taken_f, exp[i]); end
        end
    endtask

    task automatic test_collision();
        pc_f = 32'h0000_0040;
        drive(32'h0000_0040, T_BEQ, 32'd1, 32'd1, 1'b0, 1'b1);
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL collide_old got=%b exp=0", pred_taken_f); end
        step();
        en_e = 1'b0;
        #1;
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL collide_new got=%b exp=1", pred_taken_f); end
        pc_f = 32'h0000_0043;
        #1;
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL pc_low_bits got=%b exp=1", pred_taken_f); end
    endtask

    task automatic test_mispredict();
        drive(32'h0000_0080, T_BEQ, 32'd7, 32'd7, 1'b0, 1'b1);
        checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL mp_taken got=%b exp=1", mispredict_e); end
        step();
        drive(32'h0000_0080, T_BEQ, 32'd7, 32'd7, 1'b1, 1'b1);
        checks++; if (mispredict_e !== 1'b0) begin errors++; $display("FAIL mp_correct got=%b exp=0", mispredict_e); end
        step();
        drive(32'h0000_0080, T_BNE, 32'd7, 32'd7, 1'b1, 1'b1);
        checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL mp_nottaken got=%b exp=1", mispredict_e); end
        step();
        drive(32'h0000_00C0, T_BEQ, 32'd9, 32'd9, 1'b0, 1'b0);
        checks++; if (branch_e !== 1'b0) begin errors++; $display("FAIL en0_branch got=%b exp=0", branch_e); end
        checks++; if (mispredict_e !== 1'b0) begin errors++; $display("FAIL en0_mispred got=%b exp=0", mispredict_e); end
        step();
        pc_f = 32'h0000_00C0;
        #1;
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL en0_bht got=%b exp=0", pred_taken_f); end
    endtask

    task automatic test_reset_mid_run();
        pc_f = 32'h0000_0040;
        #1;
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL pre_rst_pred got=%b exp=1", pred_taken_f); end
        rst = 1'b1;
        drive(32'h0000_0040, T_BEQ, 32'd2, 32'd2, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL init_mispred_valid got=%b exp=1", mispredict_e); end
        for (int k = 1; k <= 64; k++) begin
            step();
            checks++;
            if (init_busy !== (k < 64)) begin
                errors++; $display("FAIL reinit_len cycle=%0d got=%b exp=%b", k, init_busy, (k < 64));
            end
            if (k == 30) begin
                checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL init_pred_zero got=%b exp=0", pred_taken_f); end
                checks++; if (branch_e !== 1'b1) begin errors++; $display("FAIL init_branch_valid got=%b exp=1", branch_e); end
            end
        end
        en_e = 1'b0;
        #1;
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL post_rst_pred got=%b exp=0", pred_taken_f); end
        checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL stats_clear_b got=%0d exp=0", branch_cnt); end
        checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL stats_clear_m got=%0d exp=0", mispred_cnt); end
    endtask

    task automatic test_stats();
        drive(32'h0000_00A0, T_BEQ, 32'd4, 32'd4, 1'b1, 1'b1);
        step();
        drive(32'h0000_00A0, T_BNE, 32'd4, 32'd4, 1'b0, 1'b1);
        step();
        en_e = 1'b0;
        step();
        drive(32'h0000_00A0, T_BLT, 32'd1, 32'd2, 1'b0, 1'b1);
        step();
        en_e = 1'b0;
        step();
        checks++; if (branch_cnt !== EXP_BCNT) begin errors++; $display("FAIL stats_branch got=%0d exp=%0d", branch_cnt, EXP_BCNT); end
        checks++; if (mispred_cnt !== EXP_MCNT) begin errors++; $display("FAIL stats_mispred got=%0d exp=%0d", mispred_cnt, EXP_MCNT); end
    endtask

    initial begin
        test_reset();
        test_init_values();
        test_compare();
        test_training();
        test_collision();
        test_mispredict();
        test_reset_mid_run();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
